isr_inta_ctrl: RTL
==================

Name: isr_inta_ctrl

Overview:
- In-service register and interrupt-acknowledge sequencer for the 8259A core.
- Sits directly downstream of the priority resolver. It consumes intr, isr_set and code, and feeds isr and sp back to the resolver.
- Runs the two-pulse INTA bus cycle, drives the vector byte, and executes OCW2 EOI/rotation commands.
- Also pulses irr_clr to the upstream request register so the acknowledged edge request is cleared.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising inta_n into clk (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- intr  input  1  interrupt pending from the priority resolver.
- isr_set  input  8  one-hot level to put in service, from the resolver.
- code  input  3  resolved level, from the resolver.
- inta_n  input  1  CPU interrupt acknowledge, active low, asynchronous to clk.
- aeoi  input  1  automatic-EOI mode (ICW4 bit).
- vec_base  input  5  ICW2 T7..T3.
- cmd_valid  input  1  one-cycle strobe for an OCW2 write.
- cmd  input  3  OCW2 R, SL, EOI bits.
- cmd_lvl  input  3  OCW2 L2..L0.
- isr  output  8  in-service register, to the resolver.
- sp  output  3  lowest-priority level, to the resolver.
- int_out  output  1  INT pin to the CPU.
- irr_clr  output  8  one-cycle one-hot clear to the request register.
- data_out  output  8  vector byte.
- data_oe  output  1  data bus drive enable.
- spurious  output  1  last acknowledge was spurious; held until the next INTA1.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - isr=0, sp=7, int_out=0, irr_clr=0, data_out=0, data_oe=0, spurious=0.
  - FSM in IDLE, rotate_aeoi=0, synchroniser flops set to 1.
  - Deassertion mid-cycle aborts any acknowledge in progress.
- inta_n passes through SYNC_STAGES flops. fall/rise events are single-cycle pulses on the synchronised signal.
- Event latency: a fall or rise event is seen SYNC_STAGES+1 rising edges after inta_n first samples low or high.
- FSM states: IDLE, ACK1, WAIT2, ACK2.
- IDLE:
  - int_out=intr (registered, 1-cycle lag).
  - On fall: latch lvl_q=code and set_q=isr_set.
    - If set_q!=0: isr|=set_q, irr_clr=set_q for exactly one cycle, spurious=0.
    - If set_q==0: lvl_q=7, isr unchanged, irr_clr=0, spurious=1.
  - Go to ACK1.
- ACK1:
  - int_out=0.
  - On rise: go to WAIT2.
  - Further fall events are ignored.
- WAIT2:
  - On fall: data_out={vec_base,lvl_q}, data_oe=1, go to ACK2.
- ACK2:
  - data_oe stays 1.
  - On rise: data_oe=0 and data_out=0.
  - If aeoi=1 and spurious=0: clear isr[lvl_q]; if rotate_aeoi=1, also sp<=lvl_q.
  - Go to IDLE.
- Falls in IDLE are acted on regardless of intr (a fall with intr=0 is treated as spurious).
- OCW2 commands (cmd_valid=1) are accepted in any FSM state:
  - 001 non-specific EOI: clear the highest-priority set isr bit. Priority order is sp+1, sp+2, … sp, mod 8. No-op if isr==0.
  - 011 specific EOI: clear isr[cmd_lvl].
  - 101 rotate on non-specific EOI: as 001, and sp<=cleared level. sp is unchanged if isr==0.
  - 111 rotate on specific EOI: clear isr[cmd_lvl], sp<=cmd_lvl.
  - 110 set priority: sp<=cmd_lvl.
  - 100: rotate_aeoi=1. 000: rotate_aeoi=0. 010: no-op.
- Simultaneous events in one cycle:
  - Command clear and INTA1 set: the clear is computed on the old isr, then the set is OR-ed, so the set wins on the same bit.
  - Command sp update and AEOI rotation: the AEOI rotation wins.
- isr, sp, int_out, irr_clr, data_out and data_oe are all registered outputs.

Test Plan:
- Reset release, intr=0 → isr=00, sp=7, int_out=0, data_oe=0; FSM IDLE.
- Normal mode, vec_base=5'h01, intr=1, code=3, isr_set=08:
  - int_out=1.
  - INTA1 → isr=08, irr_clr=08 for 1 cycle, int_out=0.
  - INTA2 → data_out=0B while inta_n low, data_oe drops on the rise.
  - cmd=001 → isr=00.
- AEOI with rotate_aeoi (cmd=100), code=5, isr_set=20: full INTA pair → isr returns to 00 after the second rise, sp=5.
- Spurious: intr drops and isr_set=00 before INTA1 → isr unchanged, spurious=1, irr_clr=0, data_out={vec_base,7}.
- Non-specific EOI with sp=2, isr=0x88 → clears bit 3, isr=0x80. cmd=101 from the same start → isr=0x80, sp=3.
- Same-cycle INTA1 set of bit 3 plus cmd=011 with cmd_lvl=3, isr=08 → isr=08. Also: rst_n pulsed low during ACK2 → data_oe=0 immediately, isr=00.

Source files
------------

// File: rtl/isr_inta_ctrl.sv
// rtl/isr_inta_ctrl.sv - 8259A in-service register and INTA sequencer
module isr_inta_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       intr,
  input  logic [7:0] isr_set,
  input  logic [2:0] code,
  input  logic       inta_n,
  input  logic       aeoi,
  input  logic [4:0] vec_base,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  input  logic [2:0] cmd_lvl,
  output logic [7:0] isr,
  output logic [2:0] sp,
  output logic       int_out,
  output logic [7:0] irr_clr,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       spurious
);

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

  state_t                 state_q, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   inta_d;
  logic                   inta_s, fall, rise;
  logic                   ack1, ack2_start, ack2_end;
  logic [2:0]             lvl_q;
  logic                   rotate_aeoi_q;

  logic       nse_found;
  logic [2:0] nse_lvl;
  logic [7:0] cmd_clr, aeoi_clr, ack_set;
  logic       sp_we, rot_we, rot_val, aeoi_rot;
  logic [2:0] sp_val;

  // inta_n is asynchronous; edges are detected only on the synchronised copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      inta_d <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], inta_n};
      inta_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign inta_s = sync_q[SYNC_STAGES-1];
  assign fall   = inta_d & ~inta_s;
  assign rise   = ~inta_d & inta_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt  = state_q;
    ack1       = 1'b0;
    ack2_start = 1'b0;
    ack2_end   = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        ack1      = 1'b1;
        state_nxt = ACK1;
      end
      ACK1:  if (rise) state_nxt = WAIT2;
      WAIT2: if (fall) begin
        ack2_start = 1'b1;
        state_nxt  = ACK2;
      end
      ACK2: if (rise) begin
        ack2_end  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Highest-priority in-service level, scanning from sp+1 around to sp
  always_comb begin
    logic [2:0] idx;
    nse_found = 1'b0;
    nse_lvl   = 3'd0;
    idx       = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      idx = sp + 3'(i);
      if (!nse_found && isr[idx]) begin
        nse_found = 1'b1;
        nse_lvl   = idx;
      end
    end
  end

  always_comb begin
    cmd_clr = 8'h00;
    sp_we   = 1'b0;
    sp_val  = cmd_lvl;
    rot_we  = 1'b0;
    rot_val = 1'b0;
    if (cmd_valid) begin
      case (cmd)
        3'b001: if (nse_found) cmd_clr[nse_lvl] = 1'b1;
        3'b011: cmd_clr[cmd_lvl] = 1'b1;
        3'b101: if (nse_found) begin
          cmd_clr[nse_lvl] = 1'b1;
          sp_we            = 1'b1;
          sp_val           = nse_lvl;
        end
        3'b111: begin
          cmd_clr[cmd_lvl] = 1'b1;
          sp_we            = 1'b1;
        end
        3'b110: sp_we = 1'b1;
        3'b100: begin
          rot_we  = 1'b1;
          rot_val = 1'b1;
        end
        3'b000: rot_we = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    aeoi_clr = 8'h00;
    aeoi_rot = 1'b0;
    if (ack2_end && aeoi && !spurious) begin
      aeoi_clr[lvl_q] = 1'b1;
      aeoi_rot        = rotate_aeoi_q;
    end
  end

  assign ack_set = ack1 ? isr_set : 8'h00;

  // Clears use the pre-update isr; a same-cycle INTA1 set is OR-ed in last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isr           <= 8'h00;
      sp            <= 3'd7;
      int_out       <= 1'b0;
      irr_clr       <= 8'h00;
      data_out      <= 8'h00;
      data_oe       <= 1'b0;
      spurious      <= 1'b0;
      lvl_q         <= 3'd0;
      rotate_aeoi_q <= 1'b0;
    end else begin
      isr     <= (isr & ~cmd_clr & ~aeoi_clr) | ack_set;
      irr_clr <= ack_set;
      int_out <= (state_nxt == IDLE) ? intr : 1'b0;

      if (aeoi_rot)   sp <= lvl_q;
      else if (sp_we) sp <= sp_val;

      if (rot_we) rotate_aeoi_q <= rot_val;

      if (ack1) begin
        lvl_q    <= (isr_set != 8'h00) ? code : 3'd7;
        spurious <= (isr_set == 8'h00);
      end

      if (ack2_start) begin
        data_out <= {vec_base, lvl_q};
        data_oe  <= 1'b1;
      end else if (ack2_end) begin
        data_out <= 8'h00;
        data_oe  <= 1'b0;
      end
    end
  end

endmodule
